// File: rtl/instr_class_pipe.sv
// rtl/instr_class_pipe.sv - D-stage instruction classifier with E/M/W hazard pipeline and stall generation
//
// Decodes the instruction in D into class flags, operand use times (Tuse) and
// destination/result timing, carries destination register and time-to-result
// (Tnew) through E, M and W, and raises a single stall when a D-stage operand
// cannot yet be forwarded or a HI/LO instruction must wait for mult/div.
//
// Optional feature macro: INSTR_CLASS_MD_BUSY_EN
//   defined   : internal mult/div busy counter and md stall are built
//   undefined : no counter, md_busy tied 0, md stall term 0 (external MDU)
//
// Parameters:
//   MULT_CYCLES   busy cycles after mult/multu leaves E
//   DIV_CYCLES    busy cycles after div/divu leaves E (>= MULT_CYCLES)
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   instr_d       instruction currently in D
//   stall         freeze PC and F/D; E loads a bubble
//   jump_d..md_d  D-stage class flags
//   tuse_rs/rt    D-stage operand use time, 3 = operand unused
//   a3_e/m/w      destination register per stage, 0 = no write
//   tnew_e/m      cycles until the stage's result is forwardable
//   md_busy       mult/div result pending
module instr_class_pipe #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  output logic        stall,
  output logic        jump_d,
  output logic        b_d,
  output logic        load_d,
  output logic        store_d,
  output logic        cal_r_d,
  output logic        cal_i_d,
  output logic        md_d,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [4:0]  a3_e,
  output logic [4:0]  a3_m,
  output logic [4:0]  a3_w,
  output logic [1:0]  tnew_e,
  output logic [1:0]  tnew_m,
  output logic        md_busy
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instr_d[31:26];
  assign rs    = instr_d[25:21];
  assign rt    = instr_d[20:16];
  assign rd    = instr_d[15:11];
  assign funct = instr_d[5:0];

  // shamt never affects classification
  logic unused_shamt;
  assign unused_shamt = ^instr_d[10:6];

  logic is_j, is_jal, is_jr, is_jalr;
  logic is_mf, is_mt, is_mult, is_div;

  // Class decode; the all-zero word (sll $0,$0,0) is treated as a pure nop.
  always_comb begin
    b_d     = 1'b0;
    load_d  = 1'b0;
    store_d = 1'b0;
    cal_r_d = 1'b0;
    cal_i_d = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_jalr = 1'b0;
    is_mf   = 1'b0;
    is_mt   = 1'b0;
    is_mult = 1'b0;
    is_div  = 1'b0;
    if (instr_d != 32'd0) begin
      case (op)
        6'h00: begin
          case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b:       cal_r_d = 1'b1;
            6'h08:              is_jr   = 1'b1;
            6'h09:              is_jalr = 1'b1;
            6'h10, 6'h12:       is_mf   = 1'b1;
            6'h11, 6'h13:       is_mt   = 1'b1;
            6'h18, 6'h19:       is_mult = 1'b1;
            6'h1a, 6'h1b:       is_div  = 1'b1;
            default: ;
          endcase
        end
        // regimm: only bltz (rt=0) and bgez (rt=1) are supported
        6'h01:                  b_d     = (rt == 5'd0) || (rt == 5'd1);
        6'h02:                  is_j    = 1'b1;
        6'h03:                  is_jal  = 1'b1;
        6'h04, 6'h05, 6'h06, 6'h07: b_d = 1'b1;
        6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: cal_i_d = 1'b1;
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: load_d = 1'b1;
        6'h28, 6'h29, 6'h2b:    store_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign jump_d = is_j | is_jal | is_jr | is_jalr;
  assign md_d   = is_mf | is_mt | is_mult | is_div;

  logic [4:0] a3_dec;
  logic [1:0] tnew_dec;

  always_comb begin
    tuse_rs  = 2'd3;
    tuse_rt  = 2'd3;
    a3_dec   = 5'd0;
    tnew_dec = 2'd0;
    if (b_d || is_jr || is_jalr)                         tuse_rs = 2'd0;
    else if (cal_r_d || cal_i_d || load_d || store_d || md_d) tuse_rs = 2'd1;
    if (b_d)                                             tuse_rt = 2'd0;
    else if (cal_r_d || is_mult || is_div)               tuse_rt = 2'd1;
    else if (store_d)                                    tuse_rt = 2'd2;
    if (cal_r_d || is_mf || is_jalr)                     a3_dec = rd;
    else if (cal_i_d || load_d)                          a3_dec = rt;
    else if (is_jal)                                     a3_dec = 5'd31;
    if (load_d)                                          tnew_dec = 2'd2;
    else if (cal_r_d || cal_i_d || is_mf)                tnew_dec = 2'd1;
  end

  logic [4:0] a3_e_q, a3_m_q, a3_w_q;
  logic [1:0] tnew_e_q, tnew_m_q;
  logic [4:0] a3_e_d;
  logic [1:0] tnew_e_d, tnew_m_d;

  assign a3_e   = a3_e_q;
  assign a3_m   = a3_m_q;
  assign a3_w   = a3_w_q;
  assign tnew_e = tnew_e_q;
  assign tnew_m = tnew_m_q;

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] dst, input logic [1:0] tnew);
    return (dst != 5'd0) && (dst == src) && (tuse < tnew);
  endfunction

  logic data_stall;
  logic md_stall;

  // W is never checked: the register file bypasses same-cycle writes.
  assign data_stall = hazard(rs, tuse_rs, a3_e_q, tnew_e_q) |
                      hazard(rt, tuse_rt, a3_e_q, tnew_e_q) |
                      hazard(rs, tuse_rs, a3_m_q, tnew_m_q) |
                      hazard(rt, tuse_rt, a3_m_q, tnew_m_q);

  assign stall = data_stall | md_stall;

  always_comb begin
    a3_e_d   = stall ? 5'd0 : a3_dec;
    tnew_e_d = stall ? 2'd0 : tnew_dec;
    tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_e_q   <= 5'd0;
      a3_m_q   <= 5'd0;
      a3_w_q   <= 5'd0;
      tnew_e_q <= 2'd0;
      tnew_m_q <= 2'd0;
    end else begin
      a3_e_q   <= a3_e_d;
      tnew_e_q <= tnew_e_d;
      a3_m_q   <= a3_e_q;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_m_q;
    end
  end

`ifdef INSTR_CLASS_MD_BUSY_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic          mult_e_q, div_e_q;
  logic          mult_e_d, div_e_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new md op in E reloads the counter even if a previous one is pending.
  always_comb begin
    mult_e_d = stall ? 1'b0 : is_mult;
    div_e_d  = stall ? 1'b0 : is_div;
    cnt_d    = cnt_q;
    if (div_e_q)             cnt_d = CW'(DIV_CYCLES);
    else if (mult_e_q)       cnt_d = CW'(MULT_CYCLES);
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_e_q <= 1'b0;
      div_e_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mult_e_q <= mult_e_d;
      div_e_q  <= div_e_d;
      cnt_q    <= cnt_d;
    end
  end

  assign md_busy  = (cnt_q != '0);
  assign md_stall = md_d & (md_busy | mult_e_q | div_e_q);
`else
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;
`endif

endmodule

// File: doc/instr_class_pipe.md
# instr_class_pipe

Pipelined instruction classifier and hazard controller for the five-stage MIPS core. Decodes the D-stage instruction into class flags and register-use times (Tuse), carries each instruction's destination register and time-to-result (Tnew) through E/M/W, and raises a single `stall` when a D-stage operand cannot yet be forwarded. An internal mult/div busy counter stalls HI/LO instructions until the multiply/divide result is ready. This block replaces per-stage combinational classifiers in the hazard path.

## Interface
- `MULT_CYCLES`, 5, busy cycles after mult/multu leaves E
- `DIV_CYCLES`, 10, busy cycles after div/divu leaves E; must be ≥ `MULT_CYCLES`
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; one clock domain
- `instr_d`  in  32  instruction currently in D
- `stall`  out  1  freeze PC and F/D; E loads a bubble
- `jump_d`, `b_d`, `load_d`, `store_d`, `cal_r_d`, `cal_i_d`, `md_d`  out  1 each  D-stage class flags
- `tuse_rs`, `tuse_rt`  out  2  D-stage use time; 3 = operand unused
- `a3_e`, `a3_m`, `a3_w`  out  5  destination register per stage; 0 = no write
- `tnew_e`, `tnew_m`  out  2  cycles until result is forwardable
- `md_busy`  out  1  mult/div result pending

## Operation
- Classification is combinational on `instr_d`, covering the core ISA: R-type ALU, shifts, slt/sltu, immediate ALU, lui, loads, stores, branches (beq/bne/bgtz/blez/bgez/bltz), j/jal/jr/jalr, mfhi/mflo/mthi/mtlo, mult/multu/div/divu.
- `instr_d == 0` and unknown opcodes or functs decode as nop: all flags 0, Tuse 3/3, a3 0, Tnew 0.
- rs Tuse:
  - branch, jr, jalr: 0
  - ALU, load, store, md: 1
- rt Tuse:
  - branch: 0
  - R-type ALU, shifts, mult/div: 1
  - store: 2
  - all others: 3
- Destination register (a3):
  - R-type ALU, mfhi, mflo, jalr: rd
  - I-type ALU, lui, load: rt
  - jal: 31
  - all others: 0
- Tnew at E entry:
  - load: 2
  - ALU, mfhi, mflo: 1
  - jal, jalr, and all others: 0
- Pipeline registers advance each clock:
  - W ← M
  - M ← E, with Tnew decremented and saturating at 0
  - E ← D info, or a bubble (a3 0, Tnew 0, not md) when `stall` is 1
- Data stall is asserted when, for X in {E, M} and operand r in {rs, rt}: `a3_X != 0`, `a3_X == r`, and `tuse_r < tnew_X`.
- md stall is asserted when `md_d` is 1 and either `md_busy` is 1 or E holds mult/multu/div/divu.
- `stall` is the OR of the data stall and the md stall.
- Busy counter:
  - On the clock where E holds a mult-class instruction, the counter loads `MULT_CYCLES`; for a div-class instruction, it loads `DIV_CYCLES`.
  - Otherwise it decrements when nonzero.
  - `md_busy = (count != 0)`.
  - Counter width is `$clog2(DIV_CYCLES+1)`.

## Timing
- Reset (async assert, sync release) clears:
  - all E/M/W registers to bubble
  - the counter to 0
- Resulting reset values: `md_busy` 0; `a3_*` 0; `tnew_*` 0; `stall` 0 for any `instr_d`.
- Reset asserted mid-operation discards every in-flight instruction and any pending md busy.
- `stall` and the D flags are combinational, so they are valid in the same cycle `instr_d` changes.
- Tnew and a3 appear in E one cycle after D, in M after two, and in W after three.
- A load followed by a dependent ALU instruction stalls exactly 1 cycle. A load followed by a dependent branch stalls 2 cycles.
- A dependence on a W-stage instruction never stalls; register-file bypass covers it.
- Simultaneous load of the counter (new md in E) and a nonzero count: the load wins.
- mfhi issued directly after div: 1 cycle for the div in E, then `DIV_CYCLES` busy cycles, so the stall lasts `DIV_CYCLES + 1` cycles.

## Configuration
- `INSTR_CLASS_MD_BUSY_EN` defined:
  - the busy counter and md stall are built as described
- Not defined:
  - the counter is removed and `md_busy` is tied to 0
  - the md stall term is 0, because an external MDU supplies its own busy signal
  - class flags and Tuse for md instructions are unchanged

## Test plan
- Reset low with `instr_d = 0x8C080000` (lw $t0) → `a3_e` 0, `md_busy` 0, `stall` 0. After release plus 1 clock, `a3_e` = 8 and `tnew_e` = 2.
- lw $t0, then addu $t1,$t0,$t2 in D → `stall` is 1 for one cycle. `a3_e` = 0 (bubble), then addu proceeds and `stall` = 0.
- lw $t0, then beq $t0,$zero → `stall` is 1 for two cycles.
- Writes to $0 (addu $0,$t1,$t2) followed by a reader of $0 → never stalls.
- div, then mfhi with the macro defined and `DIV_CYCLES` = 10 → `stall` is 1 for 11 cycles and `md_busy` falls on the 11th clock. Without the macro, `stall` stays 0.
- `instr_d = 0xFC000000` (unknown opcode) → all flags 0, `tuse_rs` = `tuse_rt` = 3, `a3_e` 0 after 1 clock.
